pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage MIPS32 pipeline. Drives PC write-enable, IF/ID hold and flush, and ID/EX bubble insertion. Sources of stalls and flushes:
- load-use hazards
- taken branches and jumps
- a multi-cycle MULT/DIV unit in EX
Sits beside the IF/ID and ID/EX pipeline registers and gates their updates.

Parameters:
REG_ADDR_W, 5, register-file address width
BR_PENALTY, 1, cycles of IF/ID flush after a taken branch (1..7)
MD_TIMEOUT, 64, max cycles to wait for md_done before abort (2..255)

Ports:
clock  in  1  pipeline clock
reset  in  1  synchronous, active-low reset
ifid_rs  in  REG_ADDR_W  rs field of instruction in IF/ID
ifid_rt  in  REG_ADDR_W  rt field of instruction in IF/ID
ifid_uses_rt  in  1  instruction in IF/ID reads rt
idex_mem_read  in  1  instruction in ID/EX is a load
idex_write_addr  in  REG_ADDR_W  destination register of instruction in ID/EX
branch_taken  in  1  branch resolved taken in EX this cycle
jump  in  1  jump decoded in ID this cycle
md_start  in  1  MULT/DIV issued into EX this cycle
md_done  in  1  MULT/DIV result valid (single-cycle pulse)
pc_write  out  1  PC register load enable
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID clear to NOP
idex_flush  out  1  ID/EX clear to bubble (all control zero)
md_busy  out  1  controller waiting on MULT/DIV
md_timeout  out  1  one-cycle pulse, MULT/DIV wait aborted
state_o  out  2  current FSM state (debug)

Behaviour:
- FSM states: RUN=0, BR_FLUSH=1, MD_WAIT=2; encoding 3 is illegal and recovers to RUN on the next edge.
- State, counters and md_timeout are registered. pc_write, ifid_write, ifid_flush and idex_flush are combinational from state and inputs.
- Reset (reset=0 at posedge): state=RUN, counters=0, md_timeout=0. While reset is low, outputs are forced to pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, md_busy=0.
- Reset mid-operation aborts any flush or wait immediately. No md_timeout is raised.
- Load-use hazard (lu) = idex_mem_read && idex_write_addr!=0 && (idex_write_addr==ifid_rs || (ifid_uses_rt && idex_write_addr==ifid_rt)).
- Event priority in RUN: branch_taken > md_start > lu > jump > none. Only the highest-priority event acts.
- RUN, no event: pc_write=1, ifid_write=1, flushes=0.
- RUN, lu: pc_write=0, ifid_write=0, idex_flush=1 for exactly one cycle; state stays RUN. The bubble clears idex_mem_read, so no re-trigger occurs.
- RUN, jump: pc_write=1, ifid_write=1, ifid_flush=1 (one delay-slot kill); state stays RUN.
- RUN, branch_taken: pc_write=1, ifid_flush=1, idex_flush=1.
  - If BR_PENALTY>1: load br_cnt=BR_PENALTY-1 and go to BR_FLUSH.
- BR_FLUSH: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1; br_cnt decrements each cycle; go to RUN when br_cnt==1 at the edge. Inputs other than reset are ignored.
- RUN, md_start: pc_write=1, ifid_write=1 (the issuing cycle completes normally); md_cnt=0; go to MD_WAIT.
- MD_WAIT:
  - Outputs: pc_write=0, ifid_write=0, idex_flush=1, md_busy=1.
  - md_cnt increments and saturates at 255.
  - md_done: go to RUN next edge; the release cycle behaves as RUN.
  - md_cnt==MD_TIMEOUT-1 without md_done: md_timeout=1 for one cycle, go to RUN.
  - md_done and timeout in the same cycle: done wins, no md_timeout.
  - branch_taken in MD_WAIT is ignored; EX is occupied by MULT/DIV.
- md_done while in RUN or BR_FLUSH is ignored.
- Latency: 0 cycles from hazard input to control output; 1 cycle for state transitions.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0]. Both clear on reset and saturate at all-ones.
  - perf_stall_cnt increments each cycle with pc_write=0 and reset=1.
  - perf_flush_cnt increments each cycle with ifid_flush=1 and reset=1.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_ctrl_pkg: state enum (RUN, BR_FLUSH, MD_WAIT), REG_ADDR_W default, and the zero-register constant.
- Sub-module hazard_detect: purely combinational lu comparator. Reusable for a future forwarding unit.

Test Plan:
- Load-use: idex_mem_read=1, idex_write_addr=8, ifid_rs=8 -> one cycle with pc_write=0, ifid_write=0, idex_flush=1, then pc_write=1. Repeat with addr=0 -> no stall.
- rt-gated case: idex_write_addr=9, ifid_rt=9, ifid_uses_rt=0 -> no stall; ifid_uses_rt=1 -> one stall.
- Branch with BR_PENALTY=3: branch_taken pulse -> ifid_flush=1 for 3 consecutive cycles, state_o=1 for 2 cycles, then RUN.
- MULT/DIV: md_start, md_done pulsed 10 cycles later -> md_busy=1 and pc_write=0 for 10 cycles, released the cycle after md_done.
- Timeout, MD_TIMEOUT=16: md_start with no md_done -> md_timeout pulse on wait cycle 16, return to RUN. md_done on that same cycle -> no pulse.
- Priority and reset: branch_taken+md_start+lu together -> branch flush only. reset=0 during MD_WAIT -> RUN, flush outputs=1, no md_timeout.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_BR_FLUSH = 2'd1,
        ST_MD_WAIT  = 2'd2
    } ctrl_state_e;

    localparam int REG_ADDR_W_DEF = 5;

    // Register $zero: writes to it are discarded, so it never creates a hazard.
    localparam int unsigned ZERO_REG = 0;

    localparam int BR_CNT_W = 3;
    localparam int MD_CNT_W = 8;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus: decode/EX status in, pipeline-register gating out.
// master = pipeline datapath side, slave = hazard controller.
interface pipeline_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
);
    logic [REG_ADDR_W-1:0] ifid_rs;
    logic [REG_ADDR_W-1:0] ifid_rt;
    logic                  ifid_uses_rt;
    logic                  idex_mem_read;
    logic [REG_ADDR_W-1:0] idex_write_addr;
    logic                  branch_taken;
    logic                  jump;
    logic                  md_start;
    logic                  md_done;

    logic                  pc_write;
    logic                  ifid_write;
    logic                  ifid_flush;
    logic                  idex_flush;
    logic                  md_busy;
    logic                  md_timeout;
    logic [1:0]            state_o;

    modport master (
        output ifid_rs, ifid_rt, ifid_uses_rt, idex_mem_read, idex_write_addr,
               branch_taken, jump, md_start, md_done,
        input  pc_write, ifid_write, ifid_flush, idex_flush, md_busy,
               md_timeout, state_o
    );

    modport slave (
        input  ifid_rs, ifid_rt, ifid_uses_rt, idex_mem_read, idex_write_addr,
               branch_taken, jump, md_start, md_done,
        output pc_write, ifid_write, ifid_flush, idex_flush, md_busy,
               md_timeout, state_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an IF/ID instruction that reads the register a
// load in ID/EX is about to write. Purely combinational so a forwarding unit
// can reuse it.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
)(
    input  logic                  idex_mem_read,
    input  logic [REG_ADDR_W-1:0] idex_write_addr,
    input  logic [REG_ADDR_W-1:0] ifid_rs,
    input  logic [REG_ADDR_W-1:0] ifid_rt,
    input  logic                  ifid_uses_rt,
    output logic                  load_use
);
    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

    // rt only matters when the consumer actually reads it (e.g. not for I-type ALU ops)
    always_comb begin
        load_use = idex_mem_read
                && (idex_write_addr != ZERO_ADDR)
                && ((idex_write_addr == ifid_rs)
                    || (ifid_uses_rt && (idex_write_addr == ifid_rt)));
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS32 pipeline.
// Gates PC / IF/ID / ID/EX updates for load-use stalls, taken branches,
// jumps and multi-cycle MULT/DIV waits.
// Optional build macro: HAZARD_PERF_CNT_EN adds perf_stall_cnt and
// perf_flush_cnt saturating event counters.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// ST_RUN      | normal issue; resolves branch/md_start/load-use/jump per cycle
// ST_BR_FLUSH | extra wrong-path kill cycles after a taken branch
// ST_MD_WAIT  | front end frozen, bubbles into EX until md_done or timeout
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int BR_PENALTY = 1,
    parameter int MD_TIMEOUT = 64
)(
    input  logic                  clock,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_flush_cnt
`endif
);
    localparam logic [BR_CNT_W-1:0] BR_LOAD = BR_CNT_W'(BR_PENALTY - 1);
    localparam logic [MD_CNT_W-1:0] MD_LAST = MD_CNT_W'(MD_TIMEOUT - 1);
    localparam logic [MD_CNT_W-1:0] MD_MAX  = '1;

    ctrl_state_e         state_q, state_d;
    logic [BR_CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic                md_timeout_q, md_timeout_d;

    logic load_use;
    logic pc_write, ifid_write, ifid_flush, idex_flush, md_busy;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .idex_mem_read   (hz.idex_mem_read),
        .idex_write_addr (hz.idex_write_addr),
        .ifid_rs         (hz.ifid_rs),
        .ifid_rt         (hz.ifid_rt),
        .ifid_uses_rt    (hz.ifid_uses_rt),
        .load_use        (load_use)
    );

    // State, counters and timeout pulse; reset abandons any flush or wait silently
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            br_cnt_q     <= '0;
            md_cnt_q     <= '0;
            md_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            br_cnt_q     <= br_cnt_d;
            md_cnt_q     <= md_cnt_d;
            md_timeout_q <= md_timeout_d;
        end
    end

    // Next state: branch beats md_start; only these two leave RUN
    always_comb begin
        state_d      = state_q;
        br_cnt_d     = br_cnt_q;
        md_cnt_d     = md_cnt_q;
        md_timeout_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (hz.branch_taken) begin
                    if (BR_PENALTY > 1) begin
                        br_cnt_d = BR_LOAD;
                        state_d  = ST_BR_FLUSH;
                    end
                end else if (hz.md_start) begin
                    md_cnt_d = '0;
                    state_d  = ST_MD_WAIT;
                end
            end
            ST_BR_FLUSH: begin
                br_cnt_d = br_cnt_q - 1'b1;
                // <= rather than == so a corrupted zero count cannot wrap to 7
                if (br_cnt_q <= BR_CNT_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_MD_WAIT: begin
                if (md_cnt_q != MD_MAX) begin
                    md_cnt_d = md_cnt_q + 1'b1;
                end
                // A result arriving on the last allowed cycle still counts as done
                if (hz.md_done) begin
                    state_d = ST_RUN;
                end else if (md_cnt_q == MD_LAST) begin
                    state_d      = ST_RUN;
                    md_timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Pipeline gating; defaults are the safe stall-and-flush pattern used in reset
    always_comb begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        md_busy    = 1'b0;
        if (reset) begin
            case (state_q)
                ST_RUN: begin
                    if (hz.branch_taken) begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (hz.md_start) begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                        ifid_flush = 1'b0;
                        idex_flush = 1'b0;
                    end else if (load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        ifid_flush = 1'b0;
                        idex_flush = 1'b1;
                    end else if (hz.jump) begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b0;
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                        ifid_flush = 1'b0;
                        idex_flush = 1'b0;
                    end
                end
                ST_BR_FLUSH: begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end
                ST_MD_WAIT: begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    ifid_flush = 1'b0;
                    idex_flush = 1'b1;
                    md_busy    = 1'b1;
                end
                default: begin
                    pc_write = 1'b0;
                end
            endcase
        end
    end

    assign hz.pc_write   = pc_write;
    assign hz.ifid_write = ifid_write;
    assign hz.ifid_flush = ifid_flush;
    assign hz.idex_flush = idex_flush;
    assign hz.md_busy    = md_busy;
    assign hz.md_timeout = md_timeout_q;
    assign hz.state_o    = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // Saturating counts of frozen-PC cycles and IF/ID kill cycles
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (reset && !pc_write && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (reset && ifid_flush && (perf_flush_q != '1)) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed scenarios followed by random
// traffic, all checked cycle by cycle against a behavioural model.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;
    localparam int AW  = 5;
    localparam int BRP = 3;
    localparam int MDT = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(AW)) hz ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (AW),
        .BR_PENALTY (BRP),
        .MD_TIMEOUT (MDT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .hz             (hz)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Model state: owed extra flush cycles, completed MULT/DIV wait cycles
    // (-1 = not waiting), and the timeout pulse due this cycle.
    int flush_left = 0;
    int md_wait    = -1;
    bit to_now     = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] m_stall = '0;
    logic [31:0] m_flush = '0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL cycle %0d %s: got %0h expected %0h", cyc, tag, obs, exp);
        end
    endtask

    function automatic bit load_use(input bit mr, input bit ur,
                                    input int wa, input int rs, input int rt);
        return mr && (wa != 0) && ((wa == rs) || (ur && (wa == rt)));
    endfunction

    task automatic step(input bit r, input bit bt, input bit jp, input bit ms,
                        input bit md, input bit mr, input bit ur,
                        input int wa, input int rs, input int rt);
        bit e_pc, e_ifw, e_iff, e_idf, e_busy, to_next;
        int e_state;
        @(posedge clock);
        #1;
        reset              = r;
        hz.branch_taken    = bt;
        hz.jump            = jp;
        hz.md_start        = ms;
        hz.md_done         = md;
        hz.idex_mem_read   = mr;
        hz.ifid_uses_rt    = ur;
        hz.idex_write_addr = AW'(wa);
        hz.ifid_rs         = AW'(rs);
        hz.ifid_rt         = AW'(rt);
        #3;
        cyc++;
        to_next = 1'b0;
        e_state = (flush_left > 0) ? 1 : ((md_wait >= 0) ? 2 : 0);
        e_busy  = 1'b0;
        if (!r) begin
            {e_pc, e_ifw, e_iff, e_idf} = 4'b0011;
        end else if (flush_left > 0) begin
            {e_pc, e_ifw, e_iff, e_idf} = 4'b1111;
        end else if (md_wait >= 0) begin
            {e_pc, e_ifw, e_iff, e_idf} = 4'b0001;
            e_busy = 1'b1;
        end else if (bt) begin
            {e_pc, e_ifw, e_iff, e_idf} = 4'b1111;
        end else if (ms) begin
            {e_pc, e_ifw, e_iff, e_idf} = 4'b1100;
        end else if (load_use(mr, ur, wa, rs, rt)) begin
            {e_pc, e_ifw, e_iff, e_idf} = 4'b0001;
        end else if (jp) begin
            {e_pc, e_ifw, e_iff, e_idf} = 4'b1110;
        end else begin
            {e_pc, e_ifw, e_iff, e_idf} = 4'b1100;
        end

        check("pc_write",   32'(hz.pc_write),   32'(e_pc));
        check("ifid_write", 32'(hz.ifid_write), 32'(e_ifw));
        check("ifid_flush", 32'(hz.ifid_flush), 32'(e_iff));
        check("idex_flush", 32'(hz.idex_flush), 32'(e_idf));
        check("md_busy",    32'(hz.md_busy),    32'(e_busy));
        check("md_timeout", 32'(hz.md_timeout), 32'(to_now));
        check("state_o",    32'(hz.state_o),    32'(e_state));
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall", perf_stall_cnt, m_stall);
        check("perf_flush", perf_flush_cnt, m_flush);
        if (!r) begin
            m_stall = '0;
            m_flush = '0;
        end else begin
            if (!e_pc && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (e_iff && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
        end
`endif

        // Advance the model to what the coming clock edge should produce
        if (!r) begin
            flush_left = 0;
            md_wait    = -1;
        end else if (flush_left > 0) begin
            flush_left--;
        end else if (md_wait >= 0) begin
            if (md) begin
                md_wait = -1;
            end else if (md_wait + 1 == MDT) begin
                md_wait = -1;
                to_next = 1'b1;
            end else begin
                md_wait++;
            end
        end else if (bt) begin
            flush_left = BRP - 1;
        end else if (ms) begin
            md_wait = 0;
        end
        to_now = to_next;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        hz.branch_taken    = 1'b0;
        hz.jump            = 1'b0;
        hz.md_start        = 1'b0;
        hz.md_done         = 1'b0;
        hz.idex_mem_read   = 1'b0;
        hz.ifid_uses_rt    = 1'b0;
        hz.idex_write_addr = '0;
        hz.ifid_rs         = '0;
        hz.ifid_rt         = '0;

        //   r bt jp ms md mr ur wa rs rt
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // load-use on rs, then $zero destination
        step(1, 0, 0, 0, 0, 1, 0, 8, 8, 0);
        idle(1);
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(1);

        // rt-gated comparison
        step(1, 0, 0, 0, 0, 1, 0, 9, 1, 9);
        step(1, 0, 0, 0, 0, 1, 1, 9, 1, 9);
        idle(1);

        // taken branch and jump
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // MULT/DIV released by md_done after 10 wait cycles
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(9);
        step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(2);

        // MULT/DIV timeout, branch ignored while waiting
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(5);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(10);
        idle(3);

        // done on the timeout cycle wins
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(15);
        step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(2);

        // priority: branch + md_start + load-use
        step(1, 1, 1, 1, 0, 1, 0, 8, 8, 0);
        idle(3);

        // reset during MD_WAIT and during BR_FLUSH
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(1);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // random traffic; small address range to provoke collisions
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 6,
                 $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 40,
                 $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
